// File: rtl/rst_seq.sv
// Reset sequencer: holds N_CH active-low resets low for MIN_ASSERT cycles,
// then releases them one by one every GAP cycles. Any ext_rst/sw_req request
// re-enters the hold phase and records its cause.
module rst_seq #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_ASSERT  = 16,
  parameter int unsigned GAP         = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_rst,
  input  logic            sw_req,
  output logic [N_CH-1:0] rstbs,
  output logic            ready,
  output logic [1:0]      cause
);

  localparam int unsigned CNT_MAX = (MIN_ASSERT > GAP) ? MIN_ASSERT : GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(N_CH + 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [N_CH-1:0]        rstbs_q;
  logic [N_CH-1:0]        rstbs_d;
  logic                   ready_q;
  logic [1:0]             cause_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_s;
  logic                   req;

  assign ext_s = sync_q[SYNC_STAGES-1];
  assign req   = ext_s | sw_req;

  // Synchronise the asynchronous external reset request into clk
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst};
    end
  end

  // Current release mask with the channel at idx_q added
  always_comb begin
    rstbs_d = rstbs_q;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_q == IDX_W'(i)) begin
        rstbs_d[i] = 1'b1;
      end
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstbs_q <= '0;
      ready_q <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      case (state_q)
        HOLD: begin
          if (req) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_W'(MIN_ASSERT - 1)) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (req) begin
            state_q <= HOLD;
            rstbs_q <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            cause_q <= {sw_req, ext_s};
          end else if (cnt_q == CNT_W'(GAP - 1)) begin
            rstbs_q <= rstbs_d;
            idx_q   <= idx_q + IDX_W'(1);
            cnt_q   <= '0;
            if (idx_q == IDX_W'(N_CH - 1)) begin
              ready_q <= 1'b1;
              state_q <= RUN;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (req) begin
            state_q <= HOLD;
            rstbs_q <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            cause_q <= {sw_req, ext_s};
          end
        end
        default: begin
          state_q <= HOLD;
          rstbs_q <= '0;
          ready_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rstbs = rstbs_q;
  assign ready = ready_q;
  assign cause = cause_q;

endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised reset sequencer: the next generation of the two-flop reset synchroniser. It produces N_CH active-low reset outputs, released one after another at a fixed spacing once the minimum assertion time has elapsed. It accepts a synchronous system reset, an asynchronous external reset request and a single-cycle software reset request. It sits at the top level between the board/system reset and each clock-domain-local block reset.

## Interface
- N_CH, 4: number of reset output channels (≥1)
- SYNC_STAGES, 2: flops in the ext_rst synchroniser chain (≥2)
- MIN_ASSERT, 16: minimum cycles all outputs are held low before release begins (≥1)
- GAP, 8: cycles between consecutive channel releases, and from start of release to channel 0 (≥1)

- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high system reset
- ext_rst  in  1  asynchronous active-high external reset request; synchronised internally
- sw_req  in  1  synchronous single-cycle software reset request
- rstbs  out  N_CH  per-channel active-low reset; bit 0 released first
- ready  out  1  high when all channels are released
- cause  out  2  last reset cause: bit0 ext_rst, bit1 sw_req

## Operation
- One clock and one reset; rst is synchronous and active-high. No logic uses rst asynchronously.
- ext_rst passes through a SYNC_STAGES flop chain. ext_s is the last flop. Only ext_s feeds the FSM.
- req = ext_s | sw_req.
- Counter cnt is $clog2(max(MIN_ASSERT,GAP)+1) bits wide. Channel index idx is $clog2(N_CH+1) bits wide.
- On rst = 1, the next edge sets:
  - state = HOLD, cnt = 0, idx = 0
  - rstbs = all 0, ready = 0, cause = 0
  - synchroniser chain = all 0
- rst has priority over every other input.
- FSM states:
  - HOLD: all rstbs = 0. If req = 1, cnt ← 0. Otherwise, if cnt == MIN_ASSERT-1, go to RELEASE with cnt ← 0 and idx ← 0. Otherwise cnt ← cnt+1.
  - RELEASE: if req = 1, go to HOLD. Otherwise, if cnt == GAP-1, then rstbs[idx] ← 1, idx ← idx+1, cnt ← 0. If that idx was N_CH-1, also ready ← 1 and go to RUN. Otherwise cnt ← cnt+1.
  - RUN: outputs stable. If req = 1, go to HOLD.
- Entry to HOLD from RELEASE or RUN, on the same edge:
  - rstbs ← all 0, including channels already released
  - ready ← 0, cnt ← 0
  - cause ← {sw_req, ext_s}
- cause holds its value until the next such entry or rst. Requests arriving while already in HOLD do not update cause.
- Channels released so far stay released; no channel is released out of order.

## Timing
- Number rising edges at which rst is sampled 0 as E1, E2, …
- With no requests:
  - RELEASE entered at E_MIN_ASSERT.
  - rstbs[k] rises at E_(MIN_ASSERT+(k+1)·GAP).
  - ready rises with rstbs[N_CH-1].
- Defaults: rstbs[0..3] rise at E24, E32, E40, E48; ready rises at E48.
- GAP = 1: channels release on consecutive edges.
- N_CH = 1: ready rises together with rstbs[0].
- sw_req to all rstbs low: 1 edge (the edge sampling sw_req = 1).
- ext_rst to all rstbs low: SYNC_STAGES+1 edges after ext_rst is stable high before an edge.
- ext_rst pulses shorter than one clock period are not guaranteed to be detected.
- Held ext_rst keeps HOLD restarting (cnt = 0). The MIN_ASSERT count starts after ext_s falls.
- Simultaneous sw_req and ext_s: cause = 2'b11.
- rst asserted mid-RELEASE or mid-RUN: next edge gives full reset values, including cause = 0.

## Test plan
- Power-up, defaults: rst high 3 cycles, then low. Required: rstbs = 4'b0000 until E24. Then 0001 at E24, 0011 at E32, 0111 at E40, 1111 with ready = 1 at E48. cause = 0.
- sw_req in RUN: pulse at edge T. Required: rstbs = 0, ready = 0 and cause = 2'b10 after T. Re-release of channel 0 at T+24, ready again at T+48.
- ext_rst in RUN: ext_rst raised before edge A and held 5 cycles. Required: rstbs = 0 after A+2 with cause = 2'b01. Channel 0 releases 24 edges after ext_s falls.
- Abort mid-release: sw_req at E36, when rstbs = 0011. Required: rstbs = 0000 after E36. Sequence restarts, with channel 0 released at E60.
- rst mid-RUN with cause = 2'b10: required next edge gives rstbs = 0, ready = 0, cause = 0, followed by the full power-up sequence.
- Parameter sweep (N_CH = 1, GAP = 1, MIN_ASSERT = 1, SYNC_STAGES = 3): required rstbs[0] and ready rise at E2. ext_rst reaches the outputs in 4 edges.
